// File: rtl/wrdata_driver.sv
// DFI write-data driver for HBM2 pseudo channels PC0/PC1: pops per-PC FIFO words on WR,
// delays them by the programmed write latency and packs them onto the DFI phase lanes.
module wrdata_driver #(
    parameter int DQ_WIDTH = 256,
    parameter int MAX_WL   = 16
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [3:0]          wr_lat,
    input  logic                clr_err,
    input  logic                wr_cmd_pc0,
    input  logic                wr_cmd_pc1,
    input  logic                wrdata_fifo_empty_pc0,
    input  logic                wrdata_fifo_empty_pc1,
    input  logic [DQ_WIDTH-1:0] wrdata_fifo_dout_pc0,
    input  logic [DQ_WIDTH-1:0] wrdata_fifo_dout_pc1,
    output logic                wrdata_fifo_rd_en_pc0,
    output logic                wrdata_fifo_rd_en_pc1,
    output logic [DQ_WIDTH-1:0] dfi_0_dw_wrdata_p0,
    output logic [DQ_WIDTH-1:0] dfi_0_dw_wrdata_p1,
    output logic [3:0]          dfi_0_dw_wrdata_en,
    output logic                wr_busy,
    output logic                wr_underflow
);
    localparam int Q = DQ_WIDTH / 4;

    logic [1:0]          cmd;
    logic [1:0]          empty;
    logic [DQ_WIDTH-1:0] dout [2];

    assign cmd      = {wr_cmd_pc1, wr_cmd_pc0};
    assign empty    = {wrdata_fifo_empty_pc1, wrdata_fifo_empty_pc0};
    assign dout[0]  = wrdata_fifo_dout_pc0;
    assign dout[1]  = wrdata_fifo_dout_pc1;

    logic [3:0]          wr_lat_q;
    logic                underflow_q;
    logic [MAX_WL-1:0]   line_v_q [2];
    logic [DQ_WIDTH-1:0] line_w_q [2][MAX_WL-1];
    logic [1:0]          out_v_q;
    logic [DQ_WIDTH-1:0] out_w_q [2];

    logic                busy;
    logic [1:0]          sel_v;
    logic [DQ_WIDTH-1:0] push_w [2];
    logic [DQ_WIDTH-1:0] sel_w  [2];

    // Tap 0 is the word being pushed this cycle, so latency 0 lands one cycle after the WR.
    always_comb begin
        busy = 1'b0;
        for (int p = 0; p < 2; p++) begin
            push_w[p] = (cmd[p] && !empty[p]) ? dout[p] : '0;
            busy      = busy | (|line_v_q[p]);
            if (wr_lat_q == 4'd0) begin
                sel_v[p] = cmd[p];
                sel_w[p] = push_w[p];
            end else begin
                sel_v[p] = line_v_q[p][wr_lat_q - 4'd1];
                sel_w[p] = line_w_q[p][wr_lat_q - 4'd1];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_lat_q    <= '0;
            underflow_q <= 1'b0;
            out_v_q     <= '0;
            for (int p = 0; p < 2; p++) begin
                line_v_q[p] <= '0;
                out_w_q[p]  <= '0;
                for (int k = 0; k < MAX_WL - 1; k++) begin
                    line_w_q[p][k] <= '0;
                end
            end
        end else begin
            // Latency only changes with the pipeline empty, so in-flight words keep their tap.
            if (!busy && (cmd == 2'b00)) begin
                wr_lat_q <= wr_lat;
            end
            if (|(cmd & empty)) begin
                underflow_q <= 1'b1;
            end else if (clr_err) begin
                underflow_q <= 1'b0;
            end
            for (int p = 0; p < 2; p++) begin
                line_v_q[p]    <= {line_v_q[p][MAX_WL-2:0], cmd[p]};
                line_w_q[p][0] <= push_w[p];
                for (int k = 1; k < MAX_WL - 1; k++) begin
                    line_w_q[p][k] <= line_w_q[p][k-1];
                end
                out_v_q[p] <= sel_v[p];
                out_w_q[p] <= sel_v[p] ? sel_w[p] : '0;
            end
        end
    end

    assign wrdata_fifo_rd_en_pc0 = cmd[0] & ~empty[0];
    assign wrdata_fifo_rd_en_pc1 = cmd[1] & ~empty[1];

    // PC0 owns lanes [191:128]/[63:0] of each phase, PC1 owns [255:192]/[127:64].
    assign dfi_0_dw_wrdata_p0 = {out_w_q[1][2*Q-1:Q],   out_w_q[0][2*Q-1:Q],
                                 out_w_q[1][Q-1:0],     out_w_q[0][Q-1:0]};
    assign dfi_0_dw_wrdata_p1 = {out_w_q[1][4*Q-1:3*Q], out_w_q[0][4*Q-1:3*Q],
                                 out_w_q[1][3*Q-1:2*Q], out_w_q[0][3*Q-1:2*Q]};
    assign dfi_0_dw_wrdata_en = {out_v_q[1], out_v_q[1], out_v_q[0], out_v_q[0]};

    assign wr_busy      = busy;
    assign wr_underflow = underflow_q;

endmodule

// File: tb/tb_wrdata_driver.sv
// Bench for wrdata_driver: directed scenarios followed by random traffic, each cycle compared
// against a schedule of expected DFI beats built from the WR timing and lane rules.
module tb_wrdata_driver;
    localparam int DQ  = 256;
    localparam int MWL = 16;
    localparam int NS  = 64;

    logic          clk = 1'b0;
    logic          rstn;
    logic [3:0]    wr_lat;
    logic          clr_err;
    logic          cmd0, cmd1, empty0, empty1;
    logic [DQ-1:0] dout0, dout1;
    logic          rd_en0, rd_en1;
    logic [DQ-1:0] p0, p1;
    logic [3:0]    en;
    logic          busy, uf;

    always #5 clk = ~clk;

    wrdata_driver #(.DQ_WIDTH(DQ), .MAX_WL(MWL)) dut (
        .clk(clk), .rstn(rstn), .wr_lat(wr_lat), .clr_err(clr_err),
        .wr_cmd_pc0(cmd0), .wr_cmd_pc1(cmd1),
        .wrdata_fifo_empty_pc0(empty0), .wrdata_fifo_empty_pc1(empty1),
        .wrdata_fifo_dout_pc0(dout0), .wrdata_fifo_dout_pc1(dout1),
        .wrdata_fifo_rd_en_pc0(rd_en0), .wrdata_fifo_rd_en_pc1(rd_en1),
        .dfi_0_dw_wrdata_p0(p0), .dfi_0_dw_wrdata_p1(p1),
        .dfi_0_dw_wrdata_en(en), .wr_busy(busy), .wr_underflow(uf)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_cmd = -1000;
    logic [3:0]    lat_m;
    logic          uf_m;
    logic          exp_v [2][NS];
    logic [DQ-1:0] exp_w [2][NS];

    task automatic chk(input string tag, input logic [DQ-1:0] obs, input logic [DQ-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // A WR keeps the pipeline busy for the MAX_WL cycles following it.
    function automatic logic busy_m(input int c);
        return (c > last_cmd) && (c - last_cmd <= MWL);
    endfunction

    function automatic logic [DQ-1:0] rand_word();
        logic [DQ-1:0] w;
        for (int i = 0; i < DQ / 32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    task automatic model_reset();
        for (int p = 0; p < 2; p++)
            for (int s = 0; s < NS; s++) begin
                exp_v[p][s] = 1'b0;
                exp_w[p][s] = '0;
            end
        lat_m    = 4'd0;
        uf_m     = 1'b0;
        last_cmd = -1000;
    endtask

    task automatic check_outputs();
        int s;
        logic [DQ-1:0] w0, w1, e0, e1;
        s  = cyc % NS;
        w0 = exp_v[0][s] ? exp_w[0][s] : '0;
        w1 = exp_v[1][s] ? exp_w[1][s] : '0;
        e0 = {w1[127:64],  w0[127:64],  w1[63:0],    w0[63:0]};
        e1 = {w1[255:192], w0[255:192], w1[191:128], w0[191:128]};
        chk("wrdata_en", en, {exp_v[1][s], exp_v[1][s], exp_v[0][s], exp_v[0][s]});
        chk("wrdata_p0", p0, e0);
        chk("wrdata_p1", p1, e1);
        chk("wr_busy", busy, busy_m(cyc));
        chk("wr_underflow", uf, uf_m);
        exp_v[0][s] = 1'b0;
        exp_v[1][s] = 1'b0;
    endtask

    // Inputs are already set for this cycle; model it, clock it, compare.
    task automatic step();
        int s;
        #1;
        chk("rd_en_pc0", rd_en0, cmd0 & ~empty0);
        chk("rd_en_pc1", rd_en1, cmd1 & ~empty1);
        if (cmd0) begin
            s = (cyc + lat_m + 1) % NS;
            exp_v[0][s] = 1'b1;
            exp_w[0][s] = empty0 ? '0 : dout0;
        end
        if (cmd1) begin
            s = (cyc + lat_m + 1) % NS;
            exp_v[1][s] = 1'b1;
            exp_w[1][s] = empty1 ? '0 : dout1;
        end
        if ((cmd0 && empty0) || (cmd1 && empty1)) uf_m = 1'b1;
        else if (clr_err) uf_m = 1'b0;
        if (!busy_m(cyc) && !cmd0 && !cmd1) lat_m = wr_lat;
        if (cmd0 || cmd1) last_cmd = cyc;
        @(posedge clk);
        #1;
        cyc++;
        check_outputs();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            cmd0 = 1'b0; cmd1 = 1'b0; clr_err = 1'b0;
            step();
        end
    endtask

    task automatic drain();
        while (busy_m(cyc)) idle(1);
        idle(1);
    endtask

    task automatic apply_reset();
        cmd0 = 1'b0; cmd1 = 1'b0; clr_err = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        chk("rst_en_now", en, 4'b0000);
        chk("rst_p0_now", p0, '0);
        chk("rst_busy_now", busy, 1'b0);
        model_reset();
        repeat (2) begin
            @(posedge clk);
            #1;
            cyc++;
            chk("rst_en_hold", en, 4'b0000);
        end
        rstn = 1'b1;
    endtask

    initial begin
        rstn = 1'b0; wr_lat = 4'd0; clr_err = 1'b0;
        cmd0 = 1'b0; cmd1 = 1'b0; empty0 = 1'b0; empty1 = 1'b0;
        dout0 = '0; dout1 = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_en", en, 4'b0000);
        chk("reset_p0", p0, '0);
        chk("reset_p1", p1, '0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_uf", uf, 1'b0);
        rstn = 1'b1;

        // Latency 3, single PC0 word with distinct slices.
        wr_lat = 4'd3;
        idle(2);
        dout0 = {64'hA5A5_A5A5_0000_0003, 64'hA5A5_A5A5_0000_0002,
                 64'hA5A5_A5A5_0000_0001, 64'hA5A5_A5A5_0000_0000};
        cmd0 = 1'b1;
        step();
        idle(6);

        // Latency 0, eight back-to-back PC1 words.
        wr_lat = 4'd0;
        drain();
        for (int i = 1; i <= 8; i++) begin
            cmd1 = 1'b1; dout1 = DQ'(i);
            step();
        end
        idle(3);

        // Simultaneous PC0/PC1 with distinct words.
        wr_lat = 4'd2;
        drain();
        dout0 = rand_word(); dout1 = rand_word();
        cmd0 = 1'b1; cmd1 = 1'b1;
        step();
        idle(4);

        // Underflow on PC0, then clear; then set and clear in the same cycle.
        drain();
        empty0 = 1'b1; dout0 = rand_word();
        cmd0 = 1'b1;
        step();
        empty0 = 1'b0;
        idle(4);
        clr_err = 1'b1;
        step();
        idle(2);
        empty1 = 1'b1; cmd1 = 1'b1; clr_err = 1'b1;
        step();
        empty1 = 1'b0;
        idle(3);
        clr_err = 1'b1;
        step();
        idle(1);

        // Latency change while busy only takes effect after drain.
        wr_lat = 4'd3;
        drain();
        for (int i = 0; i < 2; i++) begin
            cmd0 = 1'b1; dout0 = rand_word();
            step();
        end
        cmd0 = 1'b0;
        wr_lat = 4'd7;
        idle(MWL + 3);
        cmd0 = 1'b1; dout0 = rand_word();
        step();
        idle(10);

        // Reset with three words in flight.
        wr_lat = 4'd5;
        drain();
        for (int i = 0; i < 3; i++) begin
            cmd0 = i[0]; cmd1 = ~i[0];
            dout0 = rand_word(); dout1 = rand_word();
            step();
        end
        apply_reset();
        idle(8);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 19) == 0) wr_lat = 4'($urandom_range(0, 15));
            cmd0    = ($urandom_range(0, 2) != 0);
            cmd1    = ($urandom_range(0, 2) != 0);
            empty0  = ($urandom_range(0, 9) == 0);
            empty1  = ($urandom_range(0, 9) == 0);
            clr_err = ($urandom_range(0, 15) == 0);
            dout0   = rand_word();
            dout1   = rand_word();
            if ($urandom_range(0, 3) == 0) begin
                cmd0 = 1'b0; cmd1 = 1'b0;
            end
            step();
        end
        empty0 = 1'b0; empty1 = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
